// File: rtl/fpu_issue_if.sv
// Request/result handshake bundle between a producer/consumer and fpu_issue.
`timescale 1ns/1ps

interface fpu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_op;
    logic [2:0]  out_flags;

    // Requester / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_flags
    );

    // fpu_issue side
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_flags
    );
endinterface

// File: rtl/fpu_issue.sv
// Request FIFO plus issue/collect controller in front of a fixed-latency fpu core.
// One operation in flight; operands held stable on fpu_* from issue until the
// result is accepted downstream.
`timescale 1ns/1ps

module fpu_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FPU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fpu_issue_if.slave               bus,
    output logic [31:0]              fpu_a,
    output logic [31:0]              fpu_b,
    output logic [1:0]               fpu_op,
    input  logic [31:0]              fpu_outp,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (FPU_LAT > 0) ? $clog2(FPU_LAT + 1) : 1;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] b;
        logic [31:0] a;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    req_t               mem_q [DEPTH];
    req_t               mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [LVL_W-1:0]   level_q,      level_d;
    logic [31:0]        fpu_a_q,      fpu_a_d;
    logic [31:0]        fpu_b_q,      fpu_b_d;
    logic [1:0]         fpu_op_q,     fpu_op_d;
    logic               out_valid_q,  out_valid_d;
    logic [31:0]        out_result_q, out_result_d;
    logic [1:0]         out_op_q,     out_op_d;
    logic [2:0]         out_flags_q,  out_flags_d;
    logic               in_ready_q,   in_ready_d;
    logic               busy_q,       busy_d;

    logic               push;
    logic               issue;

    // {nan, inf, zero}; denormals fall in none of the classes
    function automatic logic [2:0] classify(input logic [31:0] v);
        logic exp_ones;
        logic exp_zero;
        logic mant_zero;
        exp_ones  = &v[30:23];
        exp_zero  = ~|v[30:23];
        mant_zero = ~|v[22:0];
        return {exp_ones & ~mant_zero, exp_ones & mant_zero, exp_zero & mant_zero};
    endfunction

    // Next-state: FIFO bookkeeping, issue/collect sequencing and registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_op_d     = fpu_op_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_flags_d  = out_flags_q;

        // A full FIFO refuses pushes even when the head leaves on the same edge
        push  = bus.in_valid & in_ready_q;
        issue = (level_q != LVL_W'(0)) &&
                ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));

        if (push) begin
            mem_d[wr_ptr_q] = req_t'{op: bus.in_op, b: bus.in_b, a: bus.in_a};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (issue) begin
            fpu_a_d  = mem_q[rd_ptr_q].a;
            fpu_b_d  = mem_q[rd_ptr_q].b;
            fpu_op_d = mem_q[rd_ptr_q].op;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, issue})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (issue) begin
                    cnt_d   = CNT_W'(FPU_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_result_d = fpu_outp;
                    out_op_d     = fpu_op_q;
                    out_flags_d  = classify(fpu_outp);
                    out_valid_d  = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (issue) begin
                        cnt_d   = CNT_W'(FPU_LAT);
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (level_d != LVL_W'(DEPTH));
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= '0;
            out_flags_q  <= 3'b001;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            fpu_op_q     <= fpu_op_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_flags_q  <= out_flags_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_op     = out_op_q;
    assign bus.out_flags  = out_flags_q;
    assign fpu_a          = fpu_a_q;
    assign fpu_b          = fpu_b_q;
    assign fpu_op         = fpu_op_q;
    assign level          = level_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: three instances (FPU_LAT 1, 0, 3) each with a
// latency-matched stand-in fpu, a vector table, directed corner sequences and
// random traffic checked against an in-order expected-result queue.
`timescale 1ns/1ps

module tb_fpu_issue;

    localparam int unsigned NL    = 3;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] res;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [NL];
    logic [31:0] in_a      [NL];
    logic [31:0] in_b      [NL];
    logic [1:0]  in_op     [NL];
    logic        out_ready [NL];

    wire         in_ready_w   [NL];
    wire         out_valid_w  [NL];
    wire  [31:0] out_result_w [NL];
    wire  [1:0]  out_op_w     [NL];
    wire  [2:0]  out_flags_w  [NL];
    wire  [31:0] fpu_a_w      [NL];
    wire  [31:0] fpu_b_w      [NL];
    wire  [1:0]  fpu_op_w     [NL];
    wire  [2:0]  level_w      [NL];
    wire         busy_w       [NL];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    vec_t vecs [7];
    exp_t exp_q [NL][$];

    always #5 clk = ~clk;

    function automatic int unsigned lat_of(input int l);
        return (l == 0) ? 1 : ((l == 1) ? 0 : 3);
    endfunction

    // Stand-in fpu: exact IEEE results for the vectors used, a mixing hash otherwise
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        logic [65:0] key;
        key = {a, b, op};
        case (key)
            {32'h40000000, 32'h40400000, 2'd0}: return 32'h40A00000;
            {32'h40000000, 32'h40400000, 2'd1}: return 32'hBF800000;
            {32'h40000000, 32'h40400000, 2'd2}: return 32'h40C00000;
            {32'h40000000, 32'h40400000, 2'd3}: return 32'h3F2AAAAB;
            {32'h3F800000, 32'h00000000, 2'd3}: return 32'h7F800000;
            {32'h00000000, 32'h00000000, 2'd3}: return 32'h7FC00000;
            {32'h40000000, 32'hC0000000, 2'd0}: return 32'h00000000;
            default: return a ^ {b[15:0], b[31:16]} ^ (32'(op) * 32'h9E3779B9);
        endcase
    endfunction

    function automatic logic [2:0] exp_flags(input logic [31:0] r);
        int unsigned e;
        int unsigned m;
        e = int'(r[30:23]);
        m = int'(r[22:0]);
        return {(e == 255) && (m != 0), (e == 255) && (m == 0), (e == 0) && (m == 0)};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        fpu_issue_if bus ();
        logic [31:0] fn_now;
        logic [31:0] fpu_outp;
        logic [31:0] pipe [LAT+1];

        assign bus.in_valid  = in_valid[g];
        assign bus.in_a      = in_a[g];
        assign bus.in_b      = in_b[g];
        assign bus.in_op     = in_op[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready_w[g]   = bus.in_ready;
        assign out_valid_w[g]  = bus.out_valid;
        assign out_result_w[g] = bus.out_result;
        assign out_op_w[g]     = bus.out_op;
        assign out_flags_w[g]  = bus.out_flags;

        fpu_issue #(.DEPTH(DEPTH), .FPU_LAT(LAT)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus),
            .fpu_a    (fpu_a_w[g]),
            .fpu_b    (fpu_b_w[g]),
            .fpu_op   (fpu_op_w[g]),
            .fpu_outp (fpu_outp),
            .level    (level_w[g]),
            .busy     (busy_w[g])
        );

        // Result becomes valid LAT edges after the operands change
        assign fn_now = fpu_model(fpu_a_w[g], fpu_b_w[g], fpu_op_w[g]);
        always @(posedge clk) begin
            for (int k = LAT; k >= 1; k--) begin
                pipe[k] <= (k == 1) ? fn_now : pipe[k-1];
            end
        end
        assign fpu_outp = (LAT == 0) ? fn_now : pipe[LAT];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Handshakes are sampled on the falling edge and take effect on the next rising edge
    task automatic mon();
        exp_t e;
        if (!rst_n) return;
        for (int l = 0; l < NL; l++) begin
            if (in_valid[l] && in_ready_w[l])
                exp_q[l].push_back(exp_t'{op: in_op[l], res: fpu_model(in_a[l], in_b[l], in_op[l])});
            if (out_valid_w[l] && out_ready[l]) begin
                if (exp_q[l].size() == 0) begin
                    check($sformatf("unexpected_result_l%0d", l), 64'(out_result_w[l]), 64'(0));
                end else begin
                    e = exp_q[l].pop_front();
                    check($sformatf("result_l%0d", l),
                          64'({out_op_w[l], out_result_w[l], out_flags_w[l]}),
                          64'({e.op, e.res, exp_flags(e.res)}));
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push(input int l, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, output int acc);
        in_valid[l] = 1'b1;
        in_a[l] = a;
        in_b[l] = b;
        in_op[l] = op;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready_w[l]) begin
                cycle();
                acc = cyc;
                break;
            end
            cycle();
        end
        in_valid[l] = 1'b0;
        check($sformatf("push_accepted_l%0d", l), 64'(acc >= 0), 64'(1));
    endtask

    task automatic wait_valid(input int l, output int n);
        n = 0;
        while (!out_valid_w[l] && n < 200) begin
            cycle();
            n++;
        end
    endtask

    task automatic drain(input int l);
        int n;
        in_valid[l] = 1'b0;
        out_ready[l] = 1'b1;
        n = 0;
        while ((busy_w[l] || level_w[l] != 3'd0 || out_valid_w[l]) && n < 300) begin
            cycle();
            n++;
        end
        check($sformatf("drain_idle_l%0d", l), 64'({busy_w[l], level_w[l], out_valid_w[l]}), 64'(0));
        check($sformatf("drain_all_l%0d", l), 64'(exp_q[l].size()), 64'(0));
    endtask

    task automatic check_reset(input int l);
        check($sformatf("rst_ctl_l%0d", l),
              64'({out_valid_w[l], out_op_w[l], out_flags_w[l], level_w[l], busy_w[l], in_ready_w[l]}),
              64'({1'b0, 2'b00, 3'b001, 3'd0, 1'b0, 1'b1}));
        check($sformatf("rst_res_l%0d", l), 64'(out_result_w[l]), 64'(0));
        check($sformatf("rst_fpu_l%0d", l), 64'({fpu_op_w[l], fpu_a_w[l]}), 64'(0));
        check($sformatf("rst_fpub_l%0d", l), 64'(fpu_b_w[l]), 64'(0));
    endtask

    // Time bound on the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        logic [31:0] snap_res;
        logic [65:0] snap_fpu;
        int idx;

        vecs[0] = '{32'h40000000, 32'h40400000, 2'd0, 32'h40A00000, 3'b000};
        vecs[1] = '{32'h40000000, 32'h40400000, 2'd1, 32'hBF800000, 3'b000};
        vecs[2] = '{32'h40000000, 32'h40400000, 2'd2, 32'h40C00000, 3'b000};
        vecs[3] = '{32'h40000000, 32'h40400000, 2'd3, 32'h3F2AAAAB, 3'b000};
        vecs[4] = '{32'h3F800000, 32'h00000000, 2'd3, 32'h7F800000, 3'b010};
        vecs[5] = '{32'h00000000, 32'h00000000, 2'd3, 32'h7FC00000, 3'b100};
        vecs[6] = '{32'h40000000, 32'hC0000000, 2'd0, 32'h00000000, 3'b001};

        for (int l = 0; l < NL; l++) begin
            in_valid[l] = 1'b0;
            in_a[l] = '0;
            in_b[l] = '0;
            in_op[l] = '0;
            out_ready[l] = 1'b0;
        end

        // Reset state
        repeat (3) cycle();
        for (int l = 0; l < NL; l++) check_reset(l);
        rst_n = 1'b1;
        cycle();

        // Vector table on every latency: accept-to-valid is FPU_LAT+2
        for (int l = 0; l < NL; l++) begin
            out_ready[l] = 1'b1;
            for (int v = 0; v < 7; v++) begin
                push(l, vecs[v].a, vecs[v].b, vecs[v].op, acc);
                wait_valid(l, n);
                check($sformatf("latency_l%0d_v%0d", l, v), 64'(n), 64'(lat_of(l) + 2));
                check($sformatf("vec_res_l%0d_v%0d", l, v), 64'(out_result_w[l]), 64'(vecs[v].res));
                check($sformatf("vec_op_l%0d_v%0d", l, v), 64'(out_op_w[l]), 64'(vecs[v].op));
                check($sformatf("vec_flags_l%0d_v%0d", l, v), 64'(out_flags_w[l]), 64'(vecs[v].flags));
            end
            drain(l);
        end

        // Back-to-back pushes; the next op issues on the out_ready edge
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_a[0] = 32'h40000000;
            in_b[0] = 32'h40400000;
            in_op[0] = 2'(k);
            check($sformatf("b2b_in_ready_%0d", k), 64'(in_ready_w[0]), 64'(1));
            cycle();
        end
        in_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(0, n);
            check($sformatf("b2b_res_%0d", k), 64'(out_result_w[0]), 64'(vecs[k].res));
            cycle();
            if (k < 3) begin
                check($sformatf("b2b_gap_%0d", k), 64'(out_valid_w[0]), 64'(0));
                check($sformatf("b2b_issue_%0d", k), 64'(fpu_op_w[0]), 64'(k + 1));
            end
        end
        drain(0);

        // Backpressure: FIFO fills to DEPTH while the result is held
        out_ready[0] = 1'b0;
        push(0, 32'h12345678, 32'h9ABCDEF0, 2'd2, acc);
        wait_valid(0, n);
        snap_res = out_result_w[0];
        snap_fpu = {fpu_op_w[0], fpu_a_w[0], fpu_b_w[0]};
        check("bp_first_res", 64'(snap_res), 64'(fpu_model(32'h12345678, 32'h9ABCDEF0, 2'd2)));
        in_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_a[0] = $urandom;
            in_b[0] = $urandom;
            in_op[0] = 2'($urandom_range(0, 3));
            cycle();
            check($sformatf("bp_hold_res_%0d", k), 64'({out_valid_w[0], out_result_w[0]}), 64'({1'b1, snap_res}));
            check($sformatf("bp_hold_fpu_%0d", k), 64'({fpu_op_w[0], fpu_a_w[0], fpu_b_w[0]}), 64'(snap_fpu));
        end
        check("bp_full", 64'({level_w[0], in_ready_w[0]}), 64'({3'd4, 1'b0}));
        check("bp_queued", 64'(exp_q[0].size()), 64'(5));
        drain(0);

        // Reset during WAIT with two requests queued
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_a[0] = vecs[k].a;
            in_b[0] = vecs[k].b;
            in_op[0] = vecs[k].op;
            cycle();
        end
        in_valid[0] = 1'b0;
        check("midop_state", 64'({busy_w[0], level_w[0], out_valid_w[0]}), 64'({1'b1, 3'd2, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(0);
        for (int l = 0; l < NL; l++) exp_q[l].delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check($sformatf("post_rst_%0d", k), 64'({out_valid_w[0], level_w[0]}), 64'(0));
        end

        // Random traffic on every latency against the in-order model
        for (int l = 0; l < NL; l++) begin
            for (int k = 0; k < 300; k++) begin
                in_valid[l] = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 3) == 0) begin
                    idx = $urandom_range(0, 6);
                    in_a[l] = vecs[idx].a;
                    in_b[l] = vecs[idx].b;
                    in_op[l] = vecs[idx].op;
                end else begin
                    in_a[l] = $urandom;
                    in_b[l] = $urandom;
                    in_op[l] = 2'($urandom_range(0, 3));
                end
                out_ready[l] = ($urandom_range(0, 99) < 50);
                cycle();
            end
            drain(l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
